mux_4_1_2_bit_arbiter_v: RTL and testbench
==========================================

MUX_4_1_2_BIT_ARBITER_V -- requirements
Module: mux_4_1_2_bit_arbiter_v

Interface
REQ-001 SHALL have parameter MAX_HOLD, default 8: maximum consecutive GRANT cycles before forced rotation while another request is pending.
REQ-002 SHALL have port i_clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 SHALL have port i_rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port i_req  input  4  request per requester; bit k belongs to requester k.
REQ-005 SHALL have ports i_code_0 .. i_code_3  input  2 each  data code of requester 0..3.
REQ-006 SHALL have port o_grant  output  4  one-hot grant, or all zero.
REQ-007 SHALL have port o_sel_code  output  2  index of the granted requester; 0 when no grant.
REQ-008 SHALL have port o_en  output  1  mux enable; high exactly when o_grant is non-zero.
REQ-009 SHALL have port o_code  output  2  registered muxed code.
REQ-010 SHALL have port o_valid  output  1  qualifies o_code.
REQ-011 SHALL have port o_busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-012 SHALL implement FSM states IDLE, GRANT and HANDOFF; o_grant, o_sel_code and o_en are decoded from registered state only.
REQ-013 IDLE: o_grant=0, o_en=0; if i_req!=0 at an edge, the FSM SHALL enter GRANT with winner = first set i_req bit scanning upward from rr_ptr, modulo 4.
REQ-014 GRANT: o_grant = one-hot(winner), o_sel_code = winner, o_en = 1; the winner SHALL be frozen for the whole grant.
REQ-015 hold_cnt SHALL reset to 0 on GRANT entry, increment each GRANT cycle, and saturate at MAX_HOLD-1.
REQ-016 GRANT SHALL exit to HANDOFF when i_req[winner]=0, or when hold_cnt=MAX_HOLD-1 and any other i_req bit is set; if both occur in the same cycle, the result is the same single exit.
REQ-017 With hold_cnt saturated and no other request pending, the grant SHALL continue indefinitely.
REQ-018 HANDOFF SHALL last exactly one cycle with o_grant=0 and o_en=0 (break-before-make).
REQ-019 On HANDOFF entry, rr_ptr SHALL become winner+1 modulo 4 (3 wraps to 0).
REQ-020 HANDOFF SHALL go to GRANT (arbitrating per REQ-013) if i_req!=0, else to IDLE.
REQ-021 o_code SHALL equal, one cycle later, i_code_<winner> as sampled in each GRANT cycle; o_valid SHALL be o_en delayed by one cycle.
REQ-022 While o_valid=0, o_code SHALL hold 2'b00.
REQ-023 Latency: a request into an IDLE arbiter SHALL produce o_en on the next edge and o_valid one edge after that.
REQ-024 A requester that raises i_req during HANDOFF SHALL be considered in that cycle's arbitration.

Reset
REQ-025 While i_rst_n=0: state=IDLE, rr_ptr=0, hold_cnt=0, and every output = 0; this SHALL take effect immediately, without waiting for a clock edge.
REQ-026 Reset asserted mid-GRANT SHALL drop o_grant and o_en asynchronously; after release, arbitration SHALL restart from rr_ptr=0.

Structure
REQ-027 FSM state encodings and the MAX_HOLD default SHALL live in shared package arb_pkg.
REQ-028 The data path SHALL be one instance of MUX_4_1_2_bit_v, with i_en driven by o_en.
REQ-029 The select driven into MUX_4_1_2_bit_v SHALL be whatever value makes its output equal i_code_<winner>; any input-ordering mismatch SHALL be compensated inside this block.
REQ-030 No other sub-modules; total RTL SHALL be 120-400 lines.

Verification
REQ-031 Reset then i_req=4'b0100, i_code_2=2'b10 -> next edge o_grant=4'b0100, o_sel_code=2, o_en=1; following edge o_code=2'b10, o_valid=1.
REQ-032 i_req=4'b1111 held steady, MAX_HOLD=8 -> grants 0,1,2,3,0 each lasting 8 cycles, separated by one-cycle HANDOFF gaps.
REQ-033 Grant to requester 3 released -> rr_ptr wraps to 0; with i_req=4'b1001, the next grant goes to 0.
REQ-034 Only i_req[1] set for 20 cycles -> o_grant=4'b0010 held continuously with no HANDOFF.
REQ-035 i_rst_n driven low mid-GRANT between clock edges -> o_grant=0, o_en=0, o_valid=0 immediately; after release with i_req=4'b0110, requester 1 is granted.
REQ-036 Per-index mapping check: for each k in 0..3, apply i_code_k=2'b01 with all other codes=2'b10 -> o_code=2'b01 while k is granted.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared definitions for the 4-way round-robin arbiter in front of the
// 2-bit 4:1 code multiplexer.
//   arb_state_t      : arbiter FSM state encoding
//   MAX_HOLD_DEFAULT : default limit on consecutive grant cycles
//   rr_pick()        : round-robin winner search
package arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_HANDOFF = 2'd2
  } arb_state_t;

  localparam int MAX_HOLD_DEFAULT = 8;

  // First set request bit, scanning upward from ptr with wrap-around.
  // Returns ptr when req is empty; callers only use it when req != 0.
  function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
    logic [1:0] idx;
    logic       found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      idx = ptr + 2'(i);
      if (!found && req[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/mux_4_1_2_bit_arbiter_v_if.sv
// Signal bundle between the requesters and the arbiter.
//   req      : request per requester (bit k = requester k)
//   code     : 2-bit data code of each requester
//   grant    : one-hot grant or zero
//   sel_code : index of the granted requester, 0 when idle
//   en       : mux enable, high while a grant is active
//   muxed    : registered code of the granted requester
//   valid    : qualifies muxed
//   busy     : arbiter not idle
// master = requester side, slave = arbiter side.
interface mux_4_1_2_bit_arbiter_v_if;
  import arb_pkg::*;

  logic [3:0] req;
  logic [1:0] code [4];
  logic [3:0] grant;
  logic [1:0] sel_code;
  logic       en;
  logic [1:0] muxed;
  logic       valid;
  logic       busy;

  modport master (
    output req, code,
    input  grant, sel_code, en, muxed, valid, busy
  );

  modport slave (
    input  req, code,
    output grant, sel_code, en, muxed, valid, busy
  );

endinterface

// File: rtl/mux_4_1_2_bit_arbiter_v_mux.sv
// 4:1 multiplexer for 2-bit codes with enable.
//   i_en  : enable; output forced to zero when low
//   i_sel : select, 0..3 picks i_d0..i_d3
//   i_d*  : data inputs
//   o_y   : selected data, combinational
module MUX_4_1_2_bit_v (
  input  logic       i_en,
  input  logic [1:0] i_sel,
  input  logic [1:0] i_d0,
  input  logic [1:0] i_d1,
  input  logic [1:0] i_d2,
  input  logic [1:0] i_d3,
  output logic [1:0] o_y
);

  always_comb begin
    o_y = '0;
    if (i_en) begin
      case (i_sel)
        2'd0:    o_y = i_d0;
        2'd1:    o_y = i_d1;
        2'd2:    o_y = i_d2;
        default: o_y = i_d3;
      endcase
    end
  end

endmodule

// File: rtl/mux_4_1_2_bit_arbiter_v.sv
// Round-robin arbiter for four requesters driving a 2-bit 4:1 code mux.
// Grants are held while the winner keeps requesting, but are forced to
// rotate after MAX_HOLD cycles if someone else is waiting. Every grant is
// followed by a one-cycle HANDOFF gap with no grant (break-before-make).
//   i_clk, i_rst_n : clock, async active-low reset
//   i_req          : request per requester
//   i_code_0..3    : code of each requester
//   o_grant        : one-hot grant or zero
//   o_sel_code     : granted index, 0 when no grant
//   o_en           : mux enable, high exactly when o_grant != 0
//   o_code/o_valid : granted code registered one cycle later, qualified
//   o_busy         : FSM not in IDLE
module mux_4_1_2_bit_arbiter_v
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = MAX_HOLD_DEFAULT
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [3:0] i_req,
  input  logic [1:0] i_code_0,
  input  logic [1:0] i_code_1,
  input  logic [1:0] i_code_2,
  input  logic [1:0] i_code_3,
  output logic [3:0] o_grant,
  output logic [1:0] o_sel_code,
  output logic       o_en,
  output logic [1:0] o_code,
  output logic       o_valid,
  output logic       o_busy
);

  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  arb_state_t    state, state_nxt;
  logic [1:0]    winner, winner_nxt;
  logic [1:0]    rr_ptr, rr_nxt;
  logic [HW-1:0] hold_cnt, hold_nxt;
  logic [1:0]    pick;
  logic          others;
  logic [1:0]    mux_y;

  assign pick   = rr_pick(i_req, rr_ptr);
  assign others = |(i_req & ~o_grant);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= ST_IDLE;
      winner   <= '0;
      rr_ptr   <= '0;
      hold_cnt <= '0;
      o_code   <= '0;
      o_valid  <= 1'b0;
    end else begin
      state    <= state_nxt;
      winner   <= winner_nxt;
      rr_ptr   <= rr_nxt;
      hold_cnt <= hold_nxt;
      // mux output is zero whenever o_en is low, so o_code reads 0 while !o_valid
      o_code   <= mux_y;
      o_valid  <= o_en;
    end
  end

  always_comb begin
    state_nxt  = state;
    winner_nxt = winner;
    rr_nxt     = rr_ptr;
    hold_nxt   = hold_cnt;
    case (state)
      ST_IDLE, ST_HANDOFF: begin
        if (i_req != '0) begin
          state_nxt  = ST_GRANT;
          winner_nxt = pick;
          hold_nxt   = '0;
        end else begin
          state_nxt  = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (!i_req[winner] || (hold_cnt == HOLD_LAST && others)) begin
          state_nxt = ST_HANDOFF;
          rr_nxt    = winner + 2'd1;
        end else if (hold_cnt != HOLD_LAST) begin
          hold_nxt  = hold_cnt + 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Grant-side outputs depend on registered state only.
  always_comb begin
    o_grant    = '0;
    o_sel_code = '0;
    o_en       = 1'b0;
    if (state == ST_GRANT) begin
      o_grant    = 4'b0001 << winner;
      o_sel_code = winner;
      o_en       = 1'b1;
    end
  end

  assign o_busy = (state != ST_IDLE);

  MUX_4_1_2_bit_v u_mux (
    .i_en  (o_en),
    .i_sel (winner),
    .i_d0  (i_code_0),
    .i_d1  (i_code_1),
    .i_d2  (i_code_2),
    .i_d3  (i_code_3),
    .o_y   (mux_y)
  );

endmodule

// File: tb/tb_mux_4_1_2_bit_arbiter_v.sv
module tb_mux_4_1_2_bit_arbiter_v;
  import arb_pkg::*;

  logic clk;
  logic rst_n;
  int   tests;
  int   failed;

  mux_4_1_2_bit_arbiter_v_if bus ();

  mux_4_1_2_bit_arbiter_v #(.MAX_HOLD(8)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_req      (bus.req),
    .i_code_0   (bus.code[0]),
    .i_code_1   (bus.code[1]),
    .i_code_2   (bus.code[2]),
    .i_code_3   (bus.code[3]),
    .o_grant    (bus.grant),
    .o_sel_code (bus.sel_code),
    .o_en       (bus.en),
    .o_code     (bus.muxed),
    .o_valid    (bus.valid),
    .o_busy     (bus.busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_codes(input logic [1:0] c0, input logic [1:0] c1,
                           input logic [1:0] c2, input logic [1:0] c3);
    bus.code[0] = c0;
    bus.code[1] = c1;
    bus.code[2] = c2;
    bus.code[3] = c3;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] exp_g;
    tests  = 0;
    failed = 0;
    rst_n  = 1'b0;
    bus.req = '0;
    set_codes(2'b00, 2'b00, 2'b00, 2'b00);

    // Reset state
    #1;
    check("rst_grant", {4'b0, bus.grant}, 8'h00);
    check("rst_en",    {7'b0, bus.en},    8'h00);
    check("rst_valid", {7'b0, bus.valid}, 8'h00);
    check("rst_busy",  {7'b0, bus.busy},  8'h00);
    check("rst_sel",   {6'b0, bus.sel_code}, 8'h00);
    check("rst_code",  {6'b0, bus.muxed}, 8'h00);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Single request from idle: o_en next edge, o_valid one edge later
    set_codes(2'b00, 2'b00, 2'b10, 2'b00);
    bus.req = 4'b0100;
    tick();
    check("lat_grant", {4'b0, bus.grant}, 8'h04);
    check("lat_sel",   {6'b0, bus.sel_code}, 8'h02);
    check("lat_en",    {7'b0, bus.en},    8'h01);
    check("lat_busy",  {7'b0, bus.busy},  8'h01);
    check("lat_valid0",{7'b0, bus.valid}, 8'h00);
    tick();
    check("lat_code",  {6'b0, bus.muxed}, 8'h02);
    check("lat_valid", {7'b0, bus.valid}, 8'h01);
    bus.req = 4'b0000;
    tick();
    check("ho_grant",  {4'b0, bus.grant}, 8'h00);
    check("ho_en",     {7'b0, bus.en},    8'h00);
    check("ho_busy",   {7'b0, bus.busy},  8'h01);
    check("ho_valid",  {7'b0, bus.valid}, 8'h01);
    tick();
    check("idle_busy", {7'b0, bus.busy},  8'h00);
    check("idle_valid",{7'b0, bus.valid}, 8'h00);
    check("idle_code", {6'b0, bus.muxed}, 8'h00);

    // rr_ptr is now 3: grant 3, release, re-raise 3 with 0 during HANDOFF
    bus.req = 4'b1000;
    tick();
    check("wrap_g3",   {4'b0, bus.grant}, 8'h08);
    bus.req = 4'b0001;
    tick();
    check("wrap_ho",   {4'b0, bus.grant}, 8'h00);
    bus.req = 4'b1001;
    tick();
    check("wrap_g0",   {4'b0, bus.grant}, 8'h01);
    check("wrap_sel",  {6'b0, bus.sel_code}, 8'h00);
    bus.req = 4'b0000;
    tick();
    tick();

    // Lone requester keeps the grant past MAX_HOLD with no gap
    bus.req = 4'b0010;
    tick();
    for (int i = 0; i < 20; i++) begin
      check($sformatf("solo_c%0d", i), {4'b0, bus.grant}, 8'h02);
      tick();
    end
    bus.req = 4'b0000;
    tick();
    tick();

    // Full contention from rr_ptr=0: 0,1,2,3,0 for 8 cycles each, 1-cycle gaps
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    set_codes(2'b00, 2'b01, 2'b10, 2'b11);
    bus.req = 4'b1111;
    tick();
    for (int s = 0; s < 5; s++) begin
      exp_g = 4'b0001 << (s % 4);
      for (int c = 0; c < 8; c++) begin
        check($sformatf("rr_s%0d_c%0d", s, c), {4'b0, bus.grant}, {4'b0, exp_g});
        tick();
      end
      if (s < 4) begin
        check($sformatf("rr_gap%0d", s), {4'b0, bus.grant}, 8'h00);
        check($sformatf("rr_gap_code%0d", s), {6'b0, bus.muxed}, 8'(s % 4));
        tick();
      end
    end
    bus.req = 4'b0000;
    tick();
    tick();
    check("rr_idle", {7'b0, bus.busy}, 8'h00);

    // Per-index mapping of the mux
    for (int k = 0; k < 4; k++) begin
      set_codes(2'b10, 2'b10, 2'b10, 2'b10);
      bus.code[k] = 2'b01;
      bus.req = 4'b0001 << k;
      tick();
      check($sformatf("map_g%0d", k), {4'b0, bus.grant}, 8'(4'b0001 << k));
      tick();
      check($sformatf("map_code%0d", k), {6'b0, bus.muxed}, 8'h01);
      bus.req = 4'b0000;
      tick();
      tick();
    end

    // Asynchronous reset mid-grant, then restart from rr_ptr=0
    bus.req = 4'b0001;
    tick();
    tick();
    check("ar_pre_valid", {7'b0, bus.valid}, 8'h01);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_grant", {4'b0, bus.grant}, 8'h00);
    check("ar_en",    {7'b0, bus.en},    8'h00);
    check("ar_valid", {7'b0, bus.valid}, 8'h00);
    check("ar_busy",  {7'b0, bus.busy},  8'h00);
    bus.req = 4'b0110;
    #1;
    rst_n = 1'b1;
    tick();
    check("ar_restart", {4'b0, bus.grant}, 8'h02);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
